// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one write port, a per-register busy scoreboard and a sequential soft-clear
// engine that zeroes one register per cycle. Register 0 reads as zero.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle IDLE write is forwarded to matching read ports
//                and the matching busy output is forced low.
//   undefined -> reads return stored contents only.
//
// state | meaning
// IDLE  | normal operation: writes and issues accepted, ready=1
// CLEAR | soft clear walking index 1..NUM_REGS-1, writes/issues dropped
module regfile_sb #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_issue,
  input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
  output logic                  busyA,
  output logic                  busyB,
  input  logic                  ctrl_clear,
  output logic                  ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_d;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = ctrl_writeEnable && (ctrl_writeReg != '0) && (state_q == IDLE);
  assign iss_ok = ctrl_issue && (ctrl_issueReg != '0) && (state_q == IDLE);
  assign ready  = (state_q == IDLE);

  // Next-state for the file, scoreboard and clear engine.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          regs_d[ctrl_writeReg] = data_writeReg;
          busy_d[ctrl_writeReg] = 1'b0;
        end
        // Issue after write so a same-cycle new producer leaves the bit set.
        if (iss_ok) begin
          busy_d[ctrl_issueReg] = 1'b1;
        end
        if (ctrl_clear) begin
          state_d = CLEAR;
          idx_d   = IDX_FIRST;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        busy_d[idx_q] = 1'b0;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = IDX_FIRST;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers; reset zeroes the file immediately and aborts any clear.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      state_q <= IDLE;
      idx_q   <= IDX_FIRST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Read port A: stored value, optionally forwarded from a same-cycle write.
  always_comb begin
    data_readRegA = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
    busyA         = (ctrl_readRegA != '0) && busy_q[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ctrl_readRegA == ctrl_writeReg)) begin
      data_readRegA = data_writeReg;
      busyA         = 1'b0;
    end
`endif
  end

  // Read port B: same rules as port A.
  always_comb begin
    data_readRegB = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];
    busyB         = (ctrl_readRegB != '0) && busy_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ctrl_readRegB == ctrl_writeReg)) begin
      data_readRegB = data_writeReg;
      busyB         = 1'b0;
    end
`endif
  end

endmodule
